safe_cpu_sequencer: RTL and testbench
=====================================

// Module: safe_cpu_sequencer
// PURPOSE
//  Downstream of the safe-wrapper control registers: turns the decoded configuration (master core,
//  safe mode, DMR/TMR select, start/end strobes) into per-core debug-halt, fetch-enable and lockstep
//  controls. It halts the participating cores, holds them while the master syncs context, releases
//  them together, and drops lockstep when the SW routine signals end. Feeds core debug_req pins and the voter.
// PARAMETERS
//  NCORES          3     number of cores in the wrapper (index 0..NCORES-1)
//  TIMEOUT_CYCLES  1024  max cycles to wait for a halt/resume ack (used only with timeout feature)
// PORTS
//  clk_i                 in   1       clock
//  rst_i                 in   1       synchronous reset, active-high
//  master_core_i         in   NCORES  one-hot master core select
//  safe_mode_i           in   1       1 = redundant execution requested
//  safe_configuration_i  in   2       00 TMR, 01 DMR, 10/11 reserved (single-core)
//  critical_section_i    in   1       1 = do not start a new halt sequence
//  start_i               in   1       level; rising edge launches the sequence
//  initial_sync_master_i in   1       level; master has finished context copy
//  end_sw_routine_i      in   1       level; SW routine ended, leave lockstep
//  debug_mode_i          in   NCORES  per-core "in debug mode" status
//  debug_req_o           out  NCORES  per-core debug halt request
//  fetch_en_o            out  NCORES  per-core fetch enable
//  lockstep_en_o         out  1       enables voter/comparator
//  active_mask_o         out  NCORES  latched participating-core mask
//  busy_o                out  1       sequencer not in IDLE
//  error_o               out  1       sticky ack-timeout flag
// BEHAVIOUR
//  - Reset (rst_i=1 at clk edge): state=IDLE; debug_req_o=0, fetch_en_o=0, lockstep_en_o=0,
//    active_mask_o=0, busy_o=0, error_o=0; start edge detector register cleared to 0.
//  - start edge = start_i & ~start_q (start_q registered each cycle). Edge while not IDLE is ignored.
//  - Mask on launch: safe_mode_i=0 or cfg 10/11 -> master_core_i only; cfg 00 -> all NCORES ones;
//    cfg 01 -> master | lowest-index non-master core. master_core_i not one-hot -> no launch, error_o=1.
//  - IDLE: fetch_en_o=master_core_i. On start edge & ~critical_section_i: latch mask/master -> HALT.
//    Start edge during critical section is dropped (not queued).
//  - HALT: debug_req_o=mask. When (debug_mode_i & mask)==mask -> SYNC (earliest 1 cycle after entry).
//  - SYNC: debug_req_o=mask, fetch_en_o=0. initial_sync_master_i=1 -> RELEASE.
//  - RELEASE: debug_req_o=0, fetch_en_o=mask. When (debug_mode_i & mask)==0 -> RUN.
//  - RUN: lockstep_en_o=1 iff popcount(mask)>1. end_sw_routine_i=1 -> DONE.
//  - DONE: lockstep_en_o=0, fetch_en_o=master only, active_mask_o cleared; start_i=0 -> IDLE.
//  - busy_o=1 in every state except IDLE. All outputs registered: 1-cycle latency from state change.
//  - end_sw_routine_i outside RUN is ignored. rst_i mid-sequence aborts to IDLE with reset values.
//  - Simultaneous ack and timeout in same cycle: ack wins.
// CONFIGURATION
//  - SAFE_SEQ_TIMEOUT_EN defined: counter cleared on entry to HALT/RELEASE; ack not reached after
//    TIMEOUT_CYCLES cycles -> error_o=1 (sticky until rst_i), all debug_req_o=0, fetch_en_o=master,
//    state -> DONE.
//  - Not defined: no counter, HALT/RELEASE wait indefinitely, error_o only flags bad master select.
// TESTING
//  - TMR: master=001,cfg=00,safe=1, start 0->1, ack 111 after 5 cyc -> debug_req=111, SYNC; sync=1 ->
//    RELEASE, ack 000 -> RUN, lockstep_en=1, active_mask=111.
//  - DMR: master=100,cfg=01 -> active_mask=101; end_sw_routine=1 in RUN -> DONE, lockstep_en=0,
//    fetch_en=100; start=0 -> IDLE, busy=0.
//  - Single: safe=0, master=010 -> mask=010, lockstep_en stays 0 through RUN.
//  - critical_section_i=1 at start edge -> stays IDLE, debug_req=000; later edge with crit=0 launches.
//  - Timeout (macro on, TIMEOUT_CYCLES=16): core 2 never acks in HALT -> error_o=1 at cycle 16,
//    debug_req=000, state DONE; rst_i=1 clears error_o.
//  - rst_i asserted in SYNC -> next cycle all outputs 0, state IDLE; bad master 011 -> error_o=1, no launch.

Source files
------------

// File: rtl/safe_cpu_sequencer_if.sv
// Configuration/control bundle between the safe-wrapper register decode and the CPU sequencer.
// The master modport drives configuration and core status; the slave modport is the sequencer.
interface safe_cpu_sequencer_if #(
  parameter int NCORES = 3
);
  logic [NCORES-1:0] master_core_i;
  logic              safe_mode_i;
  logic [1:0]        safe_configuration_i;
  logic              critical_section_i;
  logic              start_i;
  logic              initial_sync_master_i;
  logic              end_sw_routine_i;
  logic [NCORES-1:0] debug_mode_i;
  logic [NCORES-1:0] debug_req_o;
  logic [NCORES-1:0] fetch_en_o;
  logic              lockstep_en_o;
  logic [NCORES-1:0] active_mask_o;
  logic              busy_o;
  logic              error_o;

  modport master (
    output master_core_i, safe_mode_i, safe_configuration_i, critical_section_i, start_i,
           initial_sync_master_i, end_sw_routine_i, debug_mode_i,
    input  debug_req_o, fetch_en_o, lockstep_en_o, active_mask_o, busy_o, error_o
  );

  modport slave (
    input  master_core_i, safe_mode_i, safe_configuration_i, critical_section_i, start_i,
           initial_sync_master_i, end_sw_routine_i, debug_mode_i,
    output debug_req_o, fetch_en_o, lockstep_en_o, active_mask_o, busy_o, error_o
  );
endinterface

// File: rtl/safe_cpu_sequencer.sv
// Halts participating cores, holds them during master context sync, releases them together and
// drives lockstep until the SW routine ends. Define SAFE_SEQ_TIMEOUT_EN for the halt/resume ack timeout.
//
// state   | meaning
// IDLE    | only the master fetches; waiting for a start edge
// HALT    | debug halt requested on all masked cores, waiting for all to enter debug
// SYNC    | cores held in debug while the master copies context
// RELEASE | halt request dropped, fetch enabled, waiting for all cores to leave debug
// RUN     | redundant execution; voter enabled when more than one core participates
// DONE    | lockstep dropped, master only; waiting for start to be released
module safe_cpu_sequencer #(
  parameter int NCORES         = 3,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input logic           clk_i,
  input logic           rst_i,
  safe_cpu_sequencer_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HALT,
    S_SYNC,
    S_RELEASE,
    S_RUN,
    S_DONE
  } state_e;

  state_e            state_q, state_d;
  logic              start_q;
  logic [NCORES-1:0] mask_q, mask_d;
  logic [NCORES-1:0] master_q, master_d;
  logic              multi_q, multi_d;
  logic              error_q, error_d;
  logic [NCORES-1:0] dbg_q, dbg_d;
  logic [NCORES-1:0] fetch_q, fetch_d;
  logic [NCORES-1:0] amask_q, amask_d;
  logic              lock_q, lock_d;
  logic              busy_q, busy_d;

  logic              start_edge;
  logic              master_onehot;
  logic [NCORES-1:0] launch_mask;
  logic              pair_found;
  logic              halt_ack;
  logic              release_ack;
  logic              timeout;

  assign start_edge    = bus.start_i & ~start_q;
  assign master_onehot = $onehot(bus.master_core_i);
  assign halt_ack      = (bus.debug_mode_i & mask_q) == mask_q;
  assign release_ack   = (bus.debug_mode_i & mask_q) == '0;

  // DMR pairs the master with the lowest-index core that is not the master.
  always_comb begin
    launch_mask = bus.master_core_i;
    pair_found  = 1'b0;
    if (bus.safe_mode_i) begin
      if (bus.safe_configuration_i == 2'b00) begin
        launch_mask = '1;
      end else if (bus.safe_configuration_i == 2'b01) begin
        for (int i = 0; i < NCORES; i++) begin
          if (!bus.master_core_i[i] && !pair_found) begin
            launch_mask[i] = 1'b1;
            pair_found     = 1'b1;
          end
        end
      end
    end
  end

`ifdef SAFE_SEQ_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] tmr_q;

  // Reloaded on entry to a waiting state; terminal count means TIMEOUT_CYCLES cycles without ack.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tmr_q <= '0;
    end else if ((state_d == S_HALT || state_d == S_RELEASE) && state_d != state_q) begin
      tmr_q <= CNT_W'(TIMEOUT_CYCLES - 1);
    end else if (tmr_q != '0) begin
      tmr_q <= tmr_q - CNT_W'(1);
    end
  end

  assign timeout = (state_q == S_HALT || state_q == S_RELEASE) && (tmr_q == '0);
`else
  logic unused_timeout_cycles;
  assign unused_timeout_cycles = ^TIMEOUT_CYCLES;
  assign timeout               = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    mask_d   = mask_q;
    master_d = master_q;
    multi_d  = multi_q;
    error_d  = error_q;
    case (state_q)
      S_IDLE: begin
        if (start_edge && !bus.critical_section_i) begin
          if (master_onehot) begin
            state_d  = S_HALT;
            mask_d   = launch_mask;
            master_d = bus.master_core_i;
            multi_d  = $countones(launch_mask) > 1;
          end else begin
            error_d = 1'b1;
          end
        end
      end
      S_HALT: begin
        if (halt_ack) begin
          state_d = S_SYNC;
        end else if (timeout) begin
          state_d = S_DONE;
          error_d = 1'b1;
        end
      end
      S_SYNC: begin
        if (bus.initial_sync_master_i) state_d = S_RELEASE;
      end
      S_RELEASE: begin
        if (release_ack) begin
          state_d = S_RUN;
        end else if (timeout) begin
          state_d = S_DONE;
          error_d = 1'b1;
        end
      end
      S_RUN: begin
        if (bus.end_sw_routine_i) state_d = S_DONE;
      end
      S_DONE: begin
        if (!bus.start_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output decode of the current state; registered below, so outputs trail the state by one cycle.
  always_comb begin
    dbg_d   = '0;
    fetch_d = '0;
    amask_d = '0;
    lock_d  = 1'b0;
    busy_d  = 1'b1;
    case (state_q)
      S_IDLE: begin
        fetch_d = bus.master_core_i;
        busy_d  = 1'b0;
      end
      S_HALT: begin
        dbg_d   = mask_q;
        fetch_d = master_q;
        amask_d = mask_q;
      end
      S_SYNC: begin
        dbg_d   = mask_q;
        amask_d = mask_q;
      end
      S_RELEASE: begin
        fetch_d = mask_q;
        amask_d = mask_q;
      end
      S_RUN: begin
        fetch_d = mask_q;
        amask_d = mask_q;
        lock_d  = multi_q;
      end
      S_DONE: begin
        fetch_d = master_q;
      end
      default: busy_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      start_q  <= 1'b0;
      mask_q   <= '0;
      master_q <= '0;
      multi_q  <= 1'b0;
      error_q  <= 1'b0;
      dbg_q    <= '0;
      fetch_q  <= '0;
      amask_q  <= '0;
      lock_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      start_q  <= bus.start_i;
      mask_q   <= mask_d;
      master_q <= master_d;
      multi_q  <= multi_d;
      error_q  <= error_d;
      dbg_q    <= dbg_d;
      fetch_q  <= fetch_d;
      amask_q  <= amask_d;
      lock_q   <= lock_d;
      busy_q   <= busy_d;
    end
  end

  assign bus.debug_req_o   = dbg_q;
  assign bus.fetch_en_o    = fetch_q;
  assign bus.active_mask_o = amask_q;
  assign bus.lockstep_en_o = lock_q;
  assign bus.busy_o        = busy_q;
  assign bus.error_o       = error_q;

endmodule

// File: tb/tb_safe_cpu_sequencer.sv
// Scoreboard bench for safe_cpu_sequencer: expected output snapshots are queued as stimulus is
// driven and compared when the DUT reaches the corresponding state.
module tb_safe_cpu_sequencer;
  localparam int NCORES = 3;
  localparam int TCYC   = 16;

  localparam int F_DBG   = 0;
  localparam int F_FETCH = 1;
  localparam int F_LOCK  = 2;
  localparam int F_AMASK = 3;
  localparam int F_BUSY  = 4;
  localparam int F_ERR   = 5;

  logic clk_i = 1'b0;
  logic rst_i;

  always #5 clk_i = ~clk_i;

  safe_cpu_sequencer_if #(.NCORES(NCORES)) bus ();

  safe_cpu_sequencer #(
    .NCORES        (NCORES),
    .TIMEOUT_CYCLES(TCYC)
  ) dut (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .bus  (bus)
  );

  typedef struct {
    string       tag;
    logic [11:0] exp;
  } sb_t;

  sb_t sb_q[$];
  int  n_cmp = 0;
  int  n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Snapshot layout: {debug_req, fetch_en, lockstep_en, active_mask, busy, error}
  function automatic logic [11:0] mk(input logic [2:0] dbg, input logic [2:0] fetch, input logic lock,
                                     input logic [2:0] amask, input logic busy, input logic err);
    return {dbg, fetch, lock, amask, busy, err};
  endfunction

  function automatic logic [11:0] snap();
    return {bus.debug_req_o, bus.fetch_en_o, bus.lockstep_en_o, bus.active_mask_o, bus.busy_o, bus.error_o};
  endfunction

  function automatic logic [2:0] field(input int which);
    case (which)
      F_DBG:   return bus.debug_req_o;
      F_FETCH: return bus.fetch_en_o;
      F_LOCK:  return {2'b00, bus.lockstep_en_o};
      F_AMASK: return bus.active_mask_o;
      F_BUSY:  return {2'b00, bus.busy_o};
      default: return {2'b00, bus.error_o};
    endcase
  endfunction

  task automatic push(input string tag, input logic [11:0] exp);
    sb_t e;
    e.tag = tag;
    e.exp = exp;
    sb_q.push_back(e);
  endtask

  task automatic pop_check();
    sb_t e;
    if (sb_q.size() == 0) begin
      check_eq("scoreboard_underflow", sb_q.size(), 1);
    end else begin
      e = sb_q.pop_front();
      check_eq(e.tag, snap(), e.exp);
    end
  endtask

  task automatic wait_field(input string tag, input int which, input logic [2:0] val);
    int k;
    k = 0;
    while (field(which) !== val && k < 64) begin
      @(negedge clk_i);
      k++;
    end
    if (field(which) !== val) check_eq({tag, "_wait"}, field(which), val);
  endtask

  task automatic run_seq(input string tag, input logic [2:0] master, input logic safe, input logic [1:0] cfg,
                         input logic [2:0] exp_mask, input logic exp_lock);
    bus.master_core_i        = master;
    bus.safe_mode_i          = safe;
    bus.safe_configuration_i = cfg;
    bus.critical_section_i   = 1'b0;
    bus.debug_mode_i         = '0;
    bus.initial_sync_master_i = 1'b0;
    bus.end_sw_routine_i     = 1'b0;
    @(negedge clk_i);
    push({tag, "_idle"}, mk(3'b000, master, 1'b0, 3'b000, 1'b0, 1'b0));
    pop_check();

    bus.start_i = 1'b1;
    push({tag, "_halt"}, mk(exp_mask, master, 1'b0, exp_mask, 1'b1, 1'b0));
    wait_field({tag, "_halt"}, F_DBG, exp_mask);
    pop_check();

    repeat (5) @(negedge clk_i);
    bus.debug_mode_i     = exp_mask;
    bus.end_sw_routine_i = 1'b1;
    push({tag, "_sync"}, mk(exp_mask, 3'b000, 1'b0, exp_mask, 1'b1, 1'b0));
    wait_field({tag, "_sync"}, F_FETCH, 3'b000);
    repeat (2) @(negedge clk_i);
    pop_check();

    bus.end_sw_routine_i      = 1'b0;
    bus.initial_sync_master_i = 1'b1;
    push({tag, "_release"}, mk(3'b000, exp_mask, 1'b0, exp_mask, 1'b1, 1'b0));
    wait_field({tag, "_release"}, F_DBG, 3'b000);
    pop_check();

    bus.debug_mode_i          = '0;
    bus.initial_sync_master_i = 1'b0;
    push({tag, "_run"}, mk(3'b000, exp_mask, exp_lock, exp_mask, 1'b1, 1'b0));
    repeat (3) @(negedge clk_i);
    pop_check();

    bus.end_sw_routine_i = 1'b1;
    push({tag, "_done"}, mk(3'b000, master, 1'b0, 3'b000, 1'b1, 1'b0));
    wait_field({tag, "_done"}, F_AMASK, 3'b000);
    pop_check();

    bus.end_sw_routine_i = 1'b0;
    bus.start_i          = 1'b0;
    push({tag, "_back_idle"}, mk(3'b000, master, 1'b0, 3'b000, 1'b0, 1'b0));
    wait_field({tag, "_back_idle"}, F_BUSY, 3'b000);
    pop_check();
  endtask

  initial begin
    rst_i                     = 1'b1;
    bus.master_core_i         = 3'b001;
    bus.safe_mode_i           = 1'b0;
    bus.safe_configuration_i  = 2'b00;
    bus.critical_section_i    = 1'b0;
    bus.start_i               = 1'b0;
    bus.initial_sync_master_i = 1'b0;
    bus.end_sw_routine_i      = 1'b0;
    bus.debug_mode_i          = '0;

    repeat (2) @(negedge clk_i);
    push("reset", mk(3'b000, 3'b000, 1'b0, 3'b000, 1'b0, 1'b0));
    pop_check();
    rst_i = 1'b0;
    @(negedge clk_i);
    push("post_reset_idle", mk(3'b000, 3'b001, 1'b0, 3'b000, 1'b0, 1'b0));
    pop_check();

    run_seq("tmr",        3'b001, 1'b1, 2'b00, 3'b111, 1'b1);
    run_seq("dmr",        3'b100, 1'b1, 2'b01, 3'b101, 1'b1);
    run_seq("single",     3'b010, 1'b0, 2'b00, 3'b010, 1'b0);
    run_seq("dmr_m0",     3'b001, 1'b1, 2'b01, 3'b011, 1'b1);
    run_seq("dmr_m1",     3'b010, 1'b1, 2'b01, 3'b011, 1'b1);
    run_seq("reserved",   3'b010, 1'b1, 2'b10, 3'b010, 1'b0);

    // Start edge during a critical section is dropped; a later clean edge launches.
    bus.master_core_i        = 3'b001;
    bus.safe_mode_i          = 1'b1;
    bus.safe_configuration_i = 2'b00;
    bus.critical_section_i   = 1'b1;
    bus.start_i              = 1'b1;
    push("crit_dropped", mk(3'b000, 3'b001, 1'b0, 3'b000, 1'b0, 1'b0));
    repeat (4) @(negedge clk_i);
    pop_check();
    bus.critical_section_i = 1'b0;
    push("crit_not_queued", mk(3'b000, 3'b001, 1'b0, 3'b000, 1'b0, 1'b0));
    repeat (3) @(negedge clk_i);
    pop_check();
    bus.start_i = 1'b0;
    @(negedge clk_i);
    bus.start_i = 1'b1;
    push("crit_launch", mk(3'b111, 3'b001, 1'b0, 3'b111, 1'b1, 1'b0));
    wait_field("crit_launch", F_DBG, 3'b111);
    pop_check();

    bus.debug_mode_i = 3'b111;
    push("abort_sync", mk(3'b111, 3'b000, 1'b0, 3'b111, 1'b1, 1'b0));
    wait_field("abort_sync", F_FETCH, 3'b000);
    pop_check();
    rst_i            = 1'b1;
    bus.start_i      = 1'b0;
    bus.debug_mode_i = '0;
    push("abort_reset", mk(3'b000, 3'b000, 1'b0, 3'b000, 1'b0, 1'b0));
    @(negedge clk_i);
    pop_check();
    rst_i = 1'b0;
    push("abort_idle", mk(3'b000, 3'b001, 1'b0, 3'b000, 1'b0, 1'b0));
    @(negedge clk_i);
    pop_check();

    // Non-one-hot master select: flagged, no launch.
    bus.master_core_i = 3'b011;
    bus.start_i       = 1'b1;
    push("bad_master", mk(3'b000, 3'b011, 1'b0, 3'b000, 1'b0, 1'b1));
    repeat (4) @(negedge clk_i);
    pop_check();
    bus.start_i       = 1'b0;
    rst_i             = 1'b1;
    @(negedge clk_i);
    rst_i             = 1'b0;
    bus.master_core_i = 3'b001;
    push("bad_master_cleared", mk(3'b000, 3'b001, 1'b0, 3'b000, 1'b0, 1'b0));
    @(negedge clk_i);
    pop_check();

`ifdef SAFE_SEQ_TIMEOUT_EN
    begin
      int k;
      bus.safe_mode_i          = 1'b1;
      bus.safe_configuration_i = 2'b00;
      bus.debug_mode_i         = 3'b011;
      bus.start_i              = 1'b1;
      push("timeout_flag", mk(3'b111, 3'b001, 1'b0, 3'b111, 1'b1, 1'b1));
      k = 0;
      while (!bus.error_o && k < 100) begin
        @(negedge clk_i);
        k++;
      end
      check_eq("timeout_latency", k, 1 + TCYC);
      pop_check();
      push("timeout_done", mk(3'b000, 3'b001, 1'b0, 3'b000, 1'b1, 1'b1));
      @(negedge clk_i);
      pop_check();
      bus.start_i      = 1'b0;
      bus.debug_mode_i = '0;
      push("timeout_sticky_idle", mk(3'b000, 3'b001, 1'b0, 3'b000, 1'b0, 1'b1));
      wait_field("timeout_sticky_idle", F_BUSY, 3'b000);
      pop_check();
      rst_i = 1'b1;
      push("timeout_reset", mk(3'b000, 3'b000, 1'b0, 3'b000, 1'b0, 1'b0));
      @(negedge clk_i);
      pop_check();
      rst_i = 1'b0;
      @(negedge clk_i);
    end
`endif

    check_eq("scoreboard_drained", sb_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
